// File: rtl/sample_msg_router_pkg.sv
`default_nettype none
// ============================================================================
// Module : sample_msg_router_pkg
// Shared FSM encoding and header field offsets for the message router blocks.
// Rev    : 1.0
// ============================================================================
package sample_msg_router_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BODY = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Field positions are given relative to the word width: flag at WDTH-c_flag_off,
    // channel MSB at WDTH-c_chan_off, length starting at bit c_len_lsb.
    localparam int c_flag_off = 1;
    localparam int c_chan_off = 2;
    localparam int c_len_lsb  = 0;

endpackage
`default_nettype wire

// File: rtl/sample_msg_router_if.sv
`default_nettype none
// ============================================================================
// Module : sample_msg_router_if
// Input stream and sample/message output bundle of the message router.
// Rev    : 1.0
// ============================================================================
interface sample_msg_router_if #(
    parameter int WDTH   = 32,
    parameter int CHAN_W = 2
);
    logic [WDTH-1:0]   in_data;
    logic              in_nd;
    logic [WDTH-1:0]   out_samples;
    logic              out_samples_nd;
    logic [WDTH-1:0]   out_msg;
    logic              out_msg_nd;
    logic [CHAN_W-1:0] out_msg_chan;
    logic              error;

    modport master (
        output in_data, in_nd,
        input  out_samples, out_samples_nd, out_msg, out_msg_nd, out_msg_chan, error
    );

    modport slave (
        input  in_data, in_nd,
        output out_samples, out_samples_nd, out_msg, out_msg_nd, out_msg_chan, error
    );
endinterface
`default_nettype wire

// File: rtl/sample_msg_router_fifo.sv
`default_nettype none
// ============================================================================
// Module : msg_buffer_fifo
// Circular message buffer; words become readable only once committed.
// Rev    : 1.0
// ============================================================================
module msg_buffer_fifo #(
    parameter int WDTH  = 32,
    parameter int DEPTH = 128
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            i_wr_en,
    input  wire logic [WDTH-1:0] i_wr_data,
    input  wire logic            i_commit,
    input  wire logic            i_rewind,
    output logic                 o_full,
    output logic                 o_rd_valid,
    output logic [WDTH-1:0]      o_rd_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WDTH-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_cm_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_wr_inc;
    logic             r_rd_valid;
    logic [WDTH-1:0]  r_rd_data;

    // One slot always stays empty so full and empty are distinguishable.
    assign w_wr_inc = r_wr_ptr + 1'b1;
    assign o_full   = (w_wr_inc == r_rd_ptr);

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_cm_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (i_rewind) begin
                r_wr_ptr <= r_cm_ptr;
            end else if (i_wr_en) begin
                r_wr_ptr <= w_wr_inc;
                if (i_commit) begin
                    r_cm_ptr <= w_wr_inc;
                end
            end

            if (r_rd_ptr != r_cm_ptr) begin
                r_rd_data  <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_rd_valid <= 1'b1;
            end else begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sample_msg_router.sv
`default_nettype none
// ============================================================================
// Module : sample_msg_router
// Splits the input stream into immediate samples and buffered, whole messages.
// Rev    : 1.0
// ============================================================================
module sample_msg_router
    import sample_msg_router_pkg::*;
#(
    parameter int               WDTH      = 32,
    parameter int               N_CHAN    = 4,
    parameter int               LEN_W     = 8,
    parameter int               MAX_LEN   = 64,
    parameter int               BUF_DEPTH = 128,
    parameter logic [N_CHAN-1:0] CHAN_MASK = '1
) (
    input wire logic          clk,
    input wire logic          rst_n,
    sample_msg_router_if.slave bus
);
    localparam int          c_chan_w  = $clog2(N_CHAN);
    localparam logic [31:0] c_max_len = 32'(MAX_LEN);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_W-1:0]     r_cnt;
    logic [LEN_W-1:0]     w_cnt_nxt;

    logic                 w_flag;
    logic [c_chan_w-1:0]  w_chan;
    logic [LEN_W-1:0]     w_len;
    logic                 w_len_ok;
    logic                 w_chan_en;

    logic                 w_wr_en;
    logic                 w_commit;
    logic                 w_rewind;
    logic                 w_full;
    logic                 w_err;
    logic                 w_smp;
    logic                 w_rd_valid;
    logic [WDTH-1:0]      w_rd_data;

    logic [WDTH-1:0]      r_samples;
    logic                 r_samples_nd;
    logic [WDTH-1:0]      r_msg;
    logic                 r_msg_nd;
    logic [c_chan_w-1:0]  r_msg_chan;
    logic [LEN_W-1:0]     r_rd_left;
    logic                 r_error;

    assign w_flag    = bus.in_data[WDTH-c_flag_off];
    assign w_chan    = bus.in_data[WDTH-c_chan_off -: c_chan_w];
    assign w_len     = bus.in_data[c_len_lsb +: LEN_W];
    assign w_len_ok  = (32'(w_len) <= c_max_len);
    assign w_chan_en = CHAN_MASK[w_chan];

    msg_buffer_fifo #(
        .WDTH  (WDTH),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (bus.in_data),
        .i_commit   (w_commit),
        .i_rewind   (w_rewind),
        .o_full     (w_full),
        .o_rd_valid (w_rd_valid),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_wr_en     = 1'b0;
        w_commit    = 1'b0;
        w_rewind    = 1'b0;
        w_err       = 1'b0;
        w_smp       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.in_nd) begin
                    if (!w_flag) begin
                        w_smp = 1'b1;
                    end else if (!w_len_ok || !w_chan_en || w_full) begin
                        // Trust the length field to skip the body and realign.
                        w_err    = !w_len_ok || w_full;
                        w_rewind = w_len_ok && w_chan_en;
                        if (w_len != '0) begin
                            w_state_nxt = ST_DROP;
                            w_cnt_nxt   = w_len;
                        end
                    end else begin
                        w_wr_en = 1'b1;
                        if (w_len == '0) begin
                            w_commit = 1'b1;
                        end else begin
                            w_state_nxt = ST_BODY;
                            w_cnt_nxt   = w_len;
                        end
                    end
                end
            end
            ST_BODY: begin
                if (bus.in_nd) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (w_full) begin
                        w_rewind    = 1'b1;
                        w_err       = 1'b1;
                        w_state_nxt = (r_cnt == LEN_W'(1)) ? ST_IDLE : ST_DROP;
                    end else begin
                        w_wr_en = 1'b1;
                        if (r_cnt == LEN_W'(1)) begin
                            w_commit    = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            ST_DROP: begin
                if (bus.in_nd) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == LEN_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samples    <= '0;
            r_samples_nd <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_samples_nd <= w_smp;
            r_error      <= w_err;
            if (w_smp) begin
                r_samples <= bus.in_data;
            end
        end
    end

    // Only committed, legal messages reach the buffer, so a zero word count
    // always means the next word out is a header.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg      <= '0;
            r_msg_nd   <= 1'b0;
            r_msg_chan <= '0;
            r_rd_left  <= '0;
        end else begin
            r_msg_nd <= w_rd_valid;
            if (w_rd_valid) begin
                r_msg <= w_rd_data;
                if (r_rd_left == '0) begin
                    r_msg_chan <= w_rd_data[WDTH-c_chan_off -: c_chan_w];
                    r_rd_left  <= w_rd_data[c_len_lsb +: LEN_W];
                end else begin
                    r_rd_left <= r_rd_left - 1'b1;
                end
            end
        end
    end

    assign bus.out_samples    = r_samples;
    assign bus.out_samples_nd = r_samples_nd;
    assign bus.out_msg        = r_msg;
    assign bus.out_msg_nd     = r_msg_nd;
    assign bus.out_msg_chan   = r_msg_chan;
    assign bus.error          = r_error;

endmodule
`default_nettype wire
